// File: rtl/phy_rx_deserializer_if.sv
// Serial-in / parallel-out bundle between the phy_tx link and the receive deserializer.
// rx_count is present only when PHY_RX_BYTE_COUNT_EN is defined.
interface phy_rx_deserializer_if;
    logic       data_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active;
`ifdef PHY_RX_BYTE_COUNT_EN
    logic [15:0] rx_count;
`endif

    // master drives the bitstream and observes recovered bytes; slave is the deserializer
    modport master (
        output data_in,
        input  data_out,
        input  valid_out,
        input  active
`ifdef PHY_RX_BYTE_COUNT_EN
        , input rx_count
`endif
    );

    modport slave (
        input  data_in,
        output data_out,
        output valid_out,
        output active
`ifdef PHY_RX_BYTE_COUNT_EN
        , output rx_count
`endif
    );
endinterface

// File: rtl/phy_rx_deserializer.sv
// Receive deserializer: hunts for the COM symbol, locks after COM_LOCK aligned COMs, then emits non-COM bytes.
// Optional byte counter output rx_count is enabled by defining PHY_RX_BYTE_COUNT_EN.
module phy_rx_deserializer #(
    parameter logic [7:0]  COM_SYM  = 8'hBC,
    parameter int unsigned COM_LOCK = 4
) (
    input  logic                 dclk,
    input  logic                 default_values,
    phy_rx_deserializer_if.slave rx
);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        ALIGN  = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    localparam logic [3:0] LOCK_LAST = 4'(COM_LOCK - 1);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] sr;
    logic [2:0] bit_cnt;
    logic [2:0] bit_cnt_nxt;
    logic [3:0] com_cnt;
    logic [3:0] com_cnt_nxt;
    logic [7:0] data_nxt;
    logic       valid_nxt;
    logic       boundary;
    logic       is_com;

    // A boundary only has meaning once alignment has been established
    assign boundary = (bit_cnt == 3'd0) && (state != HUNT);
    assign is_com   = (sr == COM_SYM);

    always_ff @(posedge dclk) begin
        if (default_values) begin
            state <= HUNT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            HUNT: begin
                if (is_com) begin
                    state_nxt = ALIGN;
                end
            end
            ALIGN: begin
                if (boundary) begin
                    if (!is_com) begin
                        state_nxt = HUNT;
                    end else if (com_cnt == LOCK_LAST) begin
                        state_nxt = ACTIVE;
                    end
                end
            end
            ACTIVE: state_nxt = ACTIVE;
            default: state_nxt = HUNT;
        endcase
    end

    // bit_cnt restarts at 1 on a hunt hit because the COM's last bit is already in sr
    always_comb begin
        bit_cnt_nxt = bit_cnt;
        com_cnt_nxt = com_cnt;
        data_nxt    = rx.data_out;
        valid_nxt   = 1'b0;
        case (state)
            HUNT: begin
                if (is_com) begin
                    bit_cnt_nxt = 3'd1;
                    com_cnt_nxt = 4'd1;
                end
            end
            ALIGN: begin
                bit_cnt_nxt = bit_cnt + 3'd1;
                if (boundary) begin
                    if (is_com && (com_cnt != LOCK_LAST)) begin
                        com_cnt_nxt = com_cnt + 4'd1;
                    end else begin
                        com_cnt_nxt = 4'd0;
                    end
                end
            end
            ACTIVE: begin
                bit_cnt_nxt = bit_cnt + 3'd1;
                if (boundary && !is_com) begin
                    data_nxt  = sr;
                    valid_nxt = 1'b1;
                end
            end
            default: begin
                bit_cnt_nxt = 3'd0;
                com_cnt_nxt = 4'd0;
            end
        endcase
    end

    always_ff @(posedge dclk) begin
        if (default_values) begin
            sr           <= 8'h00;
            bit_cnt      <= 3'd0;
            com_cnt      <= 4'd0;
            rx.data_out  <= 8'h00;
            rx.valid_out <= 1'b0;
            rx.active    <= 1'b0;
        end else begin
            sr           <= {sr[6:0], rx.data_in};
            bit_cnt      <= bit_cnt_nxt;
            com_cnt      <= com_cnt_nxt;
            rx.data_out  <= data_nxt;
            rx.valid_out <= valid_nxt;
            rx.active    <= (state_nxt == ACTIVE);
        end
    end

`ifdef PHY_RX_BYTE_COUNT_EN
    // Saturating so a long-running link never reports a misleadingly small count
    always_ff @(posedge dclk) begin
        if (default_values) begin
            rx.rx_count <= 16'h0000;
        end else if (valid_nxt && (rx.rx_count != 16'hFFFF)) begin
            rx.rx_count <= rx.rx_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_phy_rx_deserializer.sv
// Scoreboard bench for phy_rx_deserializer: directed bitstreams, expected bytes and pulse cycles queued,
// a negedge monitor pops and compares each valid_out pulse.
module tb_phy_rx_deserializer;

    typedef struct {
        logic [7:0] data;
        int         cycle;
    } exp_t;

    logic dclk = 1'b0;
    logic default_values = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    logic first_act;
    exp_t sb_q[$];
    exp_t mon_e;

    phy_rx_deserializer_if bus();

    phy_rx_deserializer dut (
        .dclk           (dclk),
        .default_values (default_values),
        .rx             (bus)
    );

    always #5 dclk = ~dclk;

    always @(posedge dclk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic sendBit(input logic b);
        bus.data_in = b;
        @(posedge dclk);
        #1;
    endtask

    // Sends MSB first; a data byte is expected one edge after its last bit is sampled
    task automatic applyStimulus(input logic [7:0] b, input bit expect_out);
        for (int i = 7; i >= 0; i--) begin
            sendBit(b[i]);
            if (i == 7) first_act = bus.active;
        end
        if (expect_out) sb_q.push_back('{data: b, cycle: cyc + 1});
    endtask

    task automatic applyReset();
        default_values = 1'b1;
        sendBit(1'b0);
        sendBit(1'b1);
        default_values = 1'b0;
        checkOutput("reset_active", 16'(bus.active), 16'h0);
        checkOutput("reset_data", 16'(bus.data_out), 16'h0);
`ifdef PHY_RX_BYTE_COUNT_EN
        checkOutput("reset_rx_count", bus.rx_count, 16'h0);
`endif
    endtask

    always @(negedge dclk) begin
        if (bus.valid_out === 1'b1) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_valid: got data %0h at cycle %0d, expected no pulse", bus.data_out, cyc);
            end else begin
                mon_e = sb_q.pop_front();
                if ((bus.data_out !== mon_e.data) || (cyc != mon_e.cycle)) begin
                    errors++;
                    $display("[TB] FAIL byte_out: got %0h at cycle %0d, expected %0h at cycle %0d",
                             bus.data_out, cyc, mon_e.data, mon_e.cycle);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.data_in = 1'b0;
        first_act = 1'b0;

        // Reset held for 3 edges with random serial data
        default_values = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sendBit(1'($urandom_range(0, 1)));
            checkOutput("hold_reset_data", 16'(bus.data_out), 16'h0);
            checkOutput("hold_reset_valid", 16'(bus.valid_out), 16'h0);
            checkOutput("hold_reset_active", 16'(bus.active), 16'h0);
        end
        default_values = 1'b0;

        // Aligned lock, then two data bytes
        for (int i = 0; i < 4; i++) applyStimulus(8'hBC, 1'b0);
        checkOutput("lock_not_before_edge", 16'(bus.active), 16'h0);
        applyStimulus(8'hA5, 1'b1);
        checkOutput("lock_edge", 16'(first_act), 16'h1);
        applyStimulus(8'h3C, 1'b1);
        applyStimulus(8'hBC, 1'b0);
        checkOutput("active_held", 16'(bus.active), 16'h1);
        checkOutput("idle_holds_3c", 16'(bus.data_out), 16'h3C);
`ifdef PHY_RX_BYTE_COUNT_EN
        checkOutput("rx_count_two", bus.rx_count, 16'd2);
`endif

        // Lock from an arbitrary bit offset
        applyReset();
        sendBit(1'b1);
        sendBit(1'b0);
        sendBit(1'b1);
        for (int i = 0; i < 4; i++) applyStimulus(8'hBC, 1'b0);
        applyStimulus(8'h5A, 1'b1);
        applyStimulus(8'hBC, 1'b0);
        checkOutput("offset_data", 16'(bus.data_out), 16'h5A);

        // Broken COM run drops back to hunt, then relock
        applyReset();
        applyStimulus(8'hBC, 1'b0);
        applyStimulus(8'hBC, 1'b0);
        applyStimulus(8'h3C, 1'b0);
        checkOutput("no_lock_after_3c", 16'(bus.active), 16'h0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(8'hBC, 1'b0);
            checkOutput("relock_pending", 16'(bus.active), 16'h0);
        end
        applyStimulus(8'h11, 1'b1);
        checkOutput("relocked", 16'(bus.active), 16'h1);

        // Idle COMs between data bytes are dropped
        applyStimulus(8'h22, 1'b1);
        applyStimulus(8'hBC, 1'b0);
        checkOutput("idle_holds_22_a", 16'(bus.data_out), 16'h22);
        applyStimulus(8'hBC, 1'b0);
        checkOutput("idle_holds_22_b", 16'(bus.data_out), 16'h22);
        applyStimulus(8'h33, 1'b1);

        // Mid-byte reset while active
        sendBit(1'b0);
        sendBit(1'b1);
        sendBit(1'b0);
        sendBit(1'b0);
        default_values = 1'b1;
        sendBit(1'b0);
        checkOutput("midbyte_reset_data", 16'(bus.data_out), 16'h0);
        checkOutput("midbyte_reset_valid", 16'(bus.valid_out), 16'h0);
        checkOutput("midbyte_reset_active", 16'(bus.active), 16'h0);
`ifdef PHY_RX_BYTE_COUNT_EN
        checkOutput("midbyte_reset_count", bus.rx_count, 16'h0);
`endif
        default_values = 1'b0;
        for (int i = 0; i < 3; i++) applyStimulus(8'hBC, 1'b0);
        applyStimulus(8'h77, 1'b0);
        applyStimulus(8'h5A, 1'b0);
        checkOutput("no_lock_after_reset", 16'(bus.active), 16'h0);

        sendBit(1'b0);
        sendBit(1'b0);
        checkOutput("scoreboard_drained", 16'(sb_q.size()), 16'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
